// File: rtl/wb_trace_pkg.sv
// Shared defaults and entry layout for the writeback trace buffer.
// Optional build macro: WB_TRACE_TSTAMP_EN (adds a 16-bit capture timestamp per entry).
package wb_trace_pkg;

    localparam int WB_DEPTH  = 16;
    localparam int WB_DATA_W = 32;
    localparam int WB_ADDR_W = 5;
    localparam int WB_CNT_W  = 8;
    localparam int TSTAMP_W  = 16;

    // Entry layout at default widths; fields are packed addr-first, tstamp last.
    typedef struct packed {
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] data;
`ifdef WB_TRACE_TSTAMP_EN
        logic [TSTAMP_W-1:0]  tstamp;
`endif
    } wb_entry_t;

`ifdef WB_TRACE_TSTAMP_EN
    localparam int WB_ENTRY_W = WB_ADDR_W + WB_DATA_W + TSTAMP_W;
`else
    localparam int WB_ENTRY_W = WB_ADDR_W + WB_DATA_W;
`endif

endpackage

// File: rtl/wb_trace_ram.sv
// DEPTH x WIDTH entry storage for the trace buffer: synchronous write, asynchronous read.
// Entry width grows when WB_TRACE_TSTAMP_EN is defined; this module only sees WIDTH.
module wb_trace_ram
    import wb_trace_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH,
    parameter int WIDTH = WB_ENTRY_W,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // No reset on storage: the top masks the head while empty.
    always_ff @(posedge CLK) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/wb_trace_buffer.sv
// Captures committed register-file writebacks into a FWFT FIFO drained over valid/ready.
// Optional build macro: WB_TRACE_TSTAMP_EN (free-running cycle stamp stored per entry).
module wb_trace_buffer
    import wb_trace_pkg::*;
#(
    parameter int DEPTH  = WB_DEPTH,
    parameter int DATA_W = WB_DATA_W,
    parameter int ADDR_W = WB_ADDR_W,
    parameter int CNT_W  = WB_CNT_W
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     wb_we,
    input  logic [ADDR_W-1:0]        wb_addr,
    input  logic [DATA_W-1:0]        wb_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ADDR_W-1:0]        out_addr,
    output logic [DATA_W-1:0]        out_data,
`ifdef WB_TRACE_TSTAMP_EN
    output logic [TSTAMP_W-1:0]      out_tstamp,
`endif
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     overflow,
    output logic [CNT_W-1:0]         drop_cnt
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;
    localparam int LVL_W = AW + 1;
`ifdef WB_TRACE_TSTAMP_EN
    localparam int ENTRY_W = ADDR_W + DATA_W + TSTAMP_W;
`else
    localparam int ENTRY_W = ADDR_W + DATA_W;
`endif

    // Handshake: the head transfers on any rising edge where out_valid && out_ready;
    // out_valid never depends on out_ready, and the head holds until it transfers.

    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]   level_q, level_nxt;
    logic               valid_q, full_q;
    logic               ovf_q;
    logic [CNT_W-1:0]   drop_q;
    logic               push_req, pop, do_push, drop;
    logic [ENTRY_W-1:0] wr_entry, rd_entry;

`ifdef WB_TRACE_TSTAMP_EN
    logic [TSTAMP_W-1:0] tstamp_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            tstamp_q <= '0;
        end else begin
            tstamp_q <= tstamp_q + TSTAMP_W'(1);
        end
    end

    assign wr_entry = {wb_addr, wb_data, tstamp_q};
`else
    assign wr_entry = {wb_addr, wb_data};
`endif

    // x0 writes are architecturally invisible, so they are never traced.
    assign push_req = wb_we && (wb_addr != '0);
    assign pop      = valid_q && out_ready;
    assign do_push  = push_req && (!full_q || pop);
    assign drop     = push_req && full_q && !pop;

    always_comb begin
        level_nxt = level_q;
        if (do_push && !pop) begin
            level_nxt = level_q + LVL_W'(1);
        end else if (pop && !do_push) begin
            level_nxt = level_q - LVL_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            valid_q  <= 1'b0;
            full_q   <= 1'b0;
            ovf_q    <= 1'b0;
            drop_q   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            level_q <= level_nxt;
            valid_q <= (level_nxt != '0);
            full_q  <= (level_nxt == LVL_W'(DEPTH));
            if (drop) begin
                ovf_q <= 1'b1;
                if (drop_q != '1) begin
                    drop_q <= drop_q + CNT_W'(1);
                end
            end
        end
    end

    wb_trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W),
        .AW    (AW)
    ) u_ram (
        .CLK   (CLK),
        .we    (do_push && !RST),
        .waddr (wr_ptr_q[AW-1:0]),
        .wdata (wr_entry),
        .raddr (rd_ptr_q[AW-1:0]),
        .rdata (rd_entry)
    );

    // Head is forced to zero while empty so stale storage never leaks out.
    assign out_valid = valid_q;
    assign out_addr  = valid_q ? rd_entry[ENTRY_W-1 -: ADDR_W] : '0;
    assign out_data  = valid_q ? rd_entry[ENTRY_W-ADDR_W-1 -: DATA_W] : '0;
`ifdef WB_TRACE_TSTAMP_EN
    assign out_tstamp = valid_q ? rd_entry[TSTAMP_W-1:0] : '0;
`endif
    assign level     = level_q;
    assign full      = full_q;
    assign overflow  = ovf_q;
    assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Self-checking bench for wb_trace_buffer: table-driven vectors plus a FIFO scoreboard.
// Define WB_TRACE_TSTAMP_EN for both bench and RTL to exercise the timestamp build.
module tb_wb_trace_buffer;

    localparam int DEPTH  = 16;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int CNT_W  = 8;
    localparam int LVL_W  = $clog2(DEPTH) + 1;
    localparam int E_W    = ADDR_W + DATA_W;

    // ---------------- clock / reset ----------------
    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    logic              wb_we;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              out_valid, out_ready;
    logic [ADDR_W-1:0] out_addr;
    logic [DATA_W-1:0] out_data;
    logic [LVL_W-1:0]  level;
    logic              full, overflow;
    logic [CNT_W-1:0]  drop_cnt;
`ifdef WB_TRACE_TSTAMP_EN
    logic [15:0]       out_tstamp;
`endif

    wb_trace_buffer #(
        .DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .wb_we     (wb_we),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_addr  (out_addr),
        .out_data  (out_data),
`ifdef WB_TRACE_TSTAMP_EN
        .out_tstamp(out_tstamp),
`endif
        .level     (level),
        .full      (full),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt)
    );

    // ---------------- scoreboard ----------------
    logic [E_W-1:0] exp_q[$];
    int   m_drops = 0;
    logic m_ovf   = 1'b0;
    int   n_vec   = 0;
    int   n_miss  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_state();
        logic [E_W-1:0] head;
        if (exp_q.size() != 0) begin
            head = exp_q[0];
            check("out_valid", 64'(out_valid), 64'd1);
            check("out_addr", 64'(out_addr), 64'(head[E_W-1 -: ADDR_W]));
            check("out_data", 64'(out_data), 64'(head[DATA_W-1:0]));
        end else begin
            check("out_valid_empty", 64'(out_valid), 64'd0);
            check("out_addr_empty", 64'(out_addr), 64'd0);
            check("out_data_empty", 64'(out_data), 64'd0);
        end
        check("level", 64'(level), 64'(exp_q.size()));
        check("full", 64'(full), 64'(exp_q.size() == DEPTH));
        check("overflow", 64'(overflow), 64'(m_ovf));
        check("drop_cnt", 64'(drop_cnt), 64'(m_drops));
    endtask

    // ---------------- driver ----------------
    // Drive at negedge, check the state left by the previous edge, then advance the model.
    task automatic cycle(input logic we, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] data, input logic ready,
                         input logic rst = 1'b0);
        logic pop_m, push_m, full_m;
        @(negedge CLK);
        wb_we = we; wb_addr = addr; wb_data = data; out_ready = ready; RST = rst;
        check_state();
        pop_m  = (exp_q.size() != 0) && ready;
        full_m = (exp_q.size() == DEPTH);
        push_m = we && (addr != '0);
        if (rst) begin
            exp_q.delete();
            m_drops = 0;
            m_ovf   = 1'b0;
        end else begin
            if (pop_m) void'(exp_q.pop_front());
            if (push_m) begin
                if (!full_m || pop_m) begin
                    exp_q.push_back({addr, data});
                end else begin
                    m_ovf = 1'b1;
                    if (m_drops < 255) m_drops++;
                end
            end
        end
        @(posedge CLK);
    endtask

    // ---------------- vector table ----------------
    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              ready;
        int                exp_level;
    } vec_t;

    vec_t tbl[14];

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [15:0] ts[3];
        wb_we = 1'b0; wb_addr = '0; wb_data = '0; out_ready = 1'b0; RST = 1'b1;
        repeat (3) @(posedge CLK);

        // Idle after reset, three writebacks held, drain in order, x0 write ignored.
        tbl[0]  = '{1'b0, 5'd0, 32'd0,      1'b0, 0};
        tbl[1]  = '{1'b0, 5'd0, 32'd0,      1'b0, 0};
        tbl[2]  = '{1'b0, 5'd0, 32'd0,      1'b0, 0};
        tbl[3]  = '{1'b0, 5'd0, 32'd0,      1'b0, 0};
        tbl[4]  = '{1'b0, 5'd0, 32'd0,      1'b0, 0};
        tbl[5]  = '{1'b1, 5'd1, 32'd5,      1'b0, 1};
        tbl[6]  = '{1'b1, 5'd2, -32'sd3,    1'b0, 2};
        tbl[7]  = '{1'b1, 5'd3, 32'd10,     1'b0, 3};
        tbl[8]  = '{1'b0, 5'd0, 32'd0,      1'b1, 2};
        tbl[9]  = '{1'b0, 5'd0, 32'd0,      1'b1, 1};
        tbl[10] = '{1'b0, 5'd0, 32'd0,      1'b1, 0};
        tbl[11] = '{1'b0, 5'd0, 32'd0,      1'b1, 0};
        tbl[12] = '{1'b1, 5'd0, 32'h1234,   1'b0, 0};
        tbl[13] = '{1'b0, 5'd0, 32'd0,      1'b0, 0};

        @(negedge CLK);
        RST = 1'b0;
        for (int i = 0; i < 14; i++) begin
            cycle(tbl[i].we, tbl[i].addr, tbl[i].data, tbl[i].ready);
            #1;
            check("tbl_level", 64'(level), 64'(tbl[i].exp_level));
        end

        // Overfill by two with the sink stalled.
        for (int i = 0; i < DEPTH + 2; i++) begin
            cycle(1'b1, ADDR_W'(i % 31 + 1), $urandom, 1'b0);
        end
        #1;
        check("fill_full", 64'(full), 64'd1);
        check("fill_level", 64'(level), 64'(DEPTH));
        check("fill_ovf", 64'(overflow), 64'd1);
        check("fill_drops", 64'(drop_cnt), 64'd2);
        check("fill_head", 64'(out_addr), 64'd1);

        // Push and pop together while full: no drop, level unchanged.
        cycle(1'b1, 5'd7, 32'hABCD_0007, 1'b1);
        #1;
        check("fullpp_level", 64'(level), 64'(DEPTH));
        check("fullpp_drops", 64'(drop_cnt), 64'd2);

        // Drain to four entries, then reset while pushing and popping.
        for (int i = 0; i < DEPTH - 4; i++) cycle(1'b0, '0, '0, 1'b1);
        #1;
        check("pre_rst_level", 64'(level), 64'd4);
        cycle(1'b1, 5'd9, 32'h9999, 1'b1, 1'b1);
        #1;
        check("rst_level", 64'(level), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        check("rst_drops", 64'(drop_cnt), 64'd0);

        // Drop counter saturates at all-ones.
        for (int i = 0; i < DEPTH + 260; i++) cycle(1'b1, 5'd4, $urandom, 1'b0);
        #1;
        check("sat_drops", 64'(drop_cnt), 64'd255);
        check("sat_ovf", 64'(overflow), 64'd1);
        cycle(1'b0, '0, '0, 1'b0, 1'b1);

        // Random traffic against the scoreboard.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 3) != 0), ADDR_W'($urandom_range(0, 31)), $urandom,
                  ($urandom_range(0, 2) == 0));
        end
        for (int i = 0; i < DEPTH + 2; i++) cycle(1'b0, '0, '0, 1'b1);

`ifdef WB_TRACE_TSTAMP_EN
        // Entries pushed three cycles apart carry stamps three apart.
        cycle(1'b0, '0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, ADDR_W'(i + 1), DATA_W'(i), 1'b0);
            cycle(1'b0, '0, '0, 1'b0);
            cycle(1'b0, '0, '0, 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            ts[i] = out_tstamp;
            cycle(1'b0, '0, '0, 1'b1);
        end
        check("tstamp_d01", 64'(16'(ts[1] - ts[0])), 64'd3);
        check("tstamp_d12", 64'(16'(ts[2] - ts[1])), 64'd3);
`endif

        @(negedge CLK);
        check_state();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
